// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a valid/ready handshake and a one-entry skid buffer.
// Optional saturating illegal-opcode counter: define IMMGEN_ILLEGAL_CNT_EN.
module imm_gen_pipe #(
    parameter int XLEN     = 64,
    parameter int TAG_W    = 5,
    parameter int PRESHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
`ifdef IMMGEN_ILLEGAL_CNT_EN
    output logic [15:0]      o_illegal_cnt,
`endif
    output logic [TAG_W-1:0] o_tag
);

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_JALR   = 7'b1100111,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_REG    = 7'b0110011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } res_t;

    res_t        dec;
    res_t        main_q;
    res_t        skid_q;
    logic        main_valid;
    logic        skid_valid;
    logic        in_xfer;
    logic        out_xfer;
    fmt_e        dec_fmt;
    logic [31:0] imm32;
    logic        s;

    assign s = i_instr[31];

    always_comb begin
        dec_fmt = FMT_ILL;
        case (i_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: dec_fmt = FMT_I;
            OP_STORE:                 dec_fmt = FMT_S;
            OP_BRANCH:                dec_fmt = FMT_B;
            OP_LUI, OP_AUIPC:         dec_fmt = FMT_U;
            OP_JAL:                   dec_fmt = FMT_J;
            OP_REG:                   dec_fmt = FMT_R;
            default:                  dec_fmt = FMT_ILL;
        endcase
    end

    // Every format is first built as a sign-correct 32-bit value, then widened once.
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            FMT_I: imm32 = {{20{s}}, i_instr[31:20]};
            FMT_S: imm32 = {{20{s}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: begin
                if (PRESHIFT != 0)
                    imm32 = {{19{s}}, s, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
                else
                    imm32 = {{20{s}}, s, i_instr[7], i_instr[30:25], i_instr[11:8]};
            end
            FMT_U: begin
                if (PRESHIFT != 0)
                    imm32 = {i_instr[31:12], 12'b0};
                else
                    imm32 = {{12{s}}, i_instr[31:12]};
            end
            FMT_J: begin
                if (PRESHIFT != 0)
                    imm32 = {{11{s}}, s, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
                else
                    imm32 = {{12{s}}, s, i_instr[19:12], i_instr[20], i_instr[30:21]};
            end
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec.imm = XLEN'($signed(imm32));
        dec.fmt = dec_fmt;
        dec.ill = (dec_fmt == FMT_ILL);
        dec.tag = i_tag;
    end

    assign o_ready  = !skid_valid;
    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = main_valid && i_ready;

    // The skid only fills while main is held, so skid_valid implies main_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (skid_valid) begin
            if (i_ready) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (!main_valid || i_ready) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

    assign o_valid   = main_valid;
    assign o_imm     = main_q.imm;
    assign o_fmt     = main_q.fmt;
    assign o_illegal = main_q.ill;
    assign o_tag     = main_q.tag;

`ifdef IMMGEN_ILLEGAL_CNT_EN
    logic [15:0] ill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ill_cnt <= '0;
        else if (in_xfer && dec.ill && (ill_cnt != 16'hFFFF))
            ill_cnt <= ill_cnt + 16'd1;
    end

    assign o_illegal_cnt = ill_cnt;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a default (XLEN=64, PRESHIFT=1) and an XLEN=32, PRESHIFT=0 instance
// share one input stream; covers decode, backpressure ordering/stability and asynchronous reset.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_instr;
    logic [4:0]  i_tag;
    logic        i_ready;

    logic        o_ready, o_valid, o_illegal;
    logic [63:0] o_imm;
    logic [2:0]  o_fmt;
    logic [4:0]  o_tag;

    logic        d2_ready, d2_valid, d2_illegal;
    logic [31:0] d2_imm;
    logic [2:0]  d2_fmt;
    logic [4:0]  d2_tag;

`ifdef IMMGEN_ILLEGAL_CNT_EN
    logic [15:0] o_illegal_cnt;
    logic [15:0] d2_illegal_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .PRESHIFT(1)) u_dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
        .o_imm(o_imm), .o_fmt(o_fmt), .o_illegal(o_illegal),
`ifdef IMMGEN_ILLEGAL_CNT_EN
        .o_illegal_cnt(o_illegal_cnt),
`endif
        .o_tag(o_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .PRESHIFT(0)) u_dut2 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(d2_ready),
        .i_instr(i_instr), .i_tag(i_tag), .o_valid(d2_valid), .i_ready(i_ready),
        .o_imm(d2_imm), .o_fmt(d2_fmt), .o_illegal(d2_illegal),
`ifdef IMMGEN_ILLEGAL_CNT_EN
        .o_illegal_cnt(d2_illegal_cnt),
`endif
        .o_tag(d2_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic send_chk(input string name, input logic [31:0] instr, input logic [4:0] tag,
                            input logic [63:0] e64, input logic [31:0] e32, input logic [2:0] efmt);
        i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b1;
        i_instr = instr;
        i_tag   = tag;
        @(negedge clk);
        i_valid = 1'b0;
        i_instr = '0;
        check({name, "_valid"}, 64'(o_valid), 64'd1);
        check({name, "_imm"}, o_imm, e64);
        check({name, "_fmt"}, 64'(o_fmt), 64'(efmt));
        check({name, "_ill"}, 64'(o_illegal), 64'(efmt == 3'd7));
        check({name, "_tag"}, 64'(o_tag), 64'(tag));
        check({name, "_imm32"}, 64'(d2_imm), 64'(e32));
        check({name, "_fmt32"}, 64'(d2_fmt), 64'(efmt));
    endtask

    initial begin : stim
        logic [0:7]  exp_rdy;
        int          k;
        int          nout;
        logic        acc;
        logic        stalled;
        logic [4:0]  held_tag;
        logic [63:0] held_imm;

        reset   = 1'b1;
        i_valid = 1'b0;
        i_instr = '0;
        i_tag   = '0;
        i_ready = 1'b1;
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_imm", o_imm, 64'd0);
        check("rst_tag", 64'(o_tag), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

`ifdef IMMGEN_ILLEGAL_CNT_EN
        check("cnt_init", 64'(o_illegal_cnt), 64'd0);
`endif
        send_chk("addi_m1", 32'hFFF00093, 5'd3,  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1);
        send_chk("addi_max", 32'h7FF00093, 5'd12, 64'h0000_0000_0000_07FF, 32'h0000_07FF, 3'd1);
        send_chk("sd_m8",   32'hFE20BC23, 5'd4,  64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2);
        send_chk("beq_m4",  32'hFE000EE3, 5'd5,  64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFE, 3'd3);
        send_chk("lui",     32'h800000B7, 5'd6,  64'hFFFF_FFFF_8000_0000, 32'hFFF8_0000, 3'd4);
        send_chk("auipc",   32'h00001297, 5'd7,  64'h0000_0000_0000_1000, 32'h0000_0001, 3'd4);
        send_chk("jal_p8",  32'h0080006F, 5'd8,  64'h0000_0000_0000_0008, 32'h0000_0004, 3'd5);
        send_chk("jal_m4",  32'hFFDFF06F, 5'd9,  64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFE, 3'd5);
        send_chk("add_r",   32'h002081B3, 5'd10, 64'd0, 32'd0, 3'd0);
        send_chk("illegal", 32'h0000007F, 5'd31, 64'd0, 32'd0, 3'd7);
`ifdef IMMGEN_ILLEGAL_CNT_EN
        check("cnt_one", 64'(o_illegal_cnt), 64'd1);
        send_chk("addi_after", 32'h00100093, 5'd1, 64'd1, 32'd1, 3'd1);
        check("cnt_hold", 64'(o_illegal_cnt), 64'd1);
`endif
        @(negedge clk);
        check("drain_valid", 64'(o_valid), 64'd0);

        // Backpressure stream: tags 0..7, i_ready low on cycles 2..4.
        exp_rdy = 8'b1110_0011;
        k = 0; nout = 0; acc = 1'b0; stalled = 1'b0;
        held_tag = '0; held_imm = '0;
        for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
            @(negedge clk);
            if (acc) k++;
            i_ready = !(cyc >= 2 && cyc <= 4);
            if (cyc < 8)
                check($sformatf("bp_ready%0d", cyc), 64'(o_ready), 64'(exp_rdy[cyc]));
            if (stalled) begin
                check($sformatf("bp_stable_tag%0d", cyc), 64'(o_tag), 64'(held_tag));
                check($sformatf("bp_stable_imm%0d", cyc), o_imm, held_imm);
            end
            if (k < 8) begin
                i_valid = 1'b1;
                i_instr = {12'(k), 5'd0, 3'b000, 5'd1, 7'b0010011};
                i_tag   = 5'(k);
            end else begin
                i_valid = 1'b0;
            end
            acc = i_valid && o_ready;
            if (o_valid && i_ready) begin
                check($sformatf("bp_tag%0d", nout), 64'(o_tag), 64'(nout));
                check($sformatf("bp_imm%0d", nout), o_imm, 64'(nout));
                nout++;
            end
            stalled  = o_valid && !i_ready;
            held_tag = o_tag;
            held_imm = o_imm;
        end
        check("bp_count", 64'(nout), 64'd8);
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_no_extra", 64'(o_valid), 64'd0);

        // Fill main and skid under stall, then reset between clock edges.
        i_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b1; i_instr = 32'h00100093; i_tag = 5'd20;
        @(negedge clk);
        i_tag = 5'd21;
        @(negedge clk);
        i_valid = 1'b0;
        check("full_valid", 64'(o_valid), 64'd1);
        check("full_ready", 64'(o_ready), 64'd0);
        check("full_tag", 64'(o_tag), 64'd20);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", 64'(o_valid), 64'd0);
        check("arst_ready", 64'(o_ready), 64'd1);
        check("arst_imm", o_imm, 64'd0);
        check("arst_fmt", 64'(o_fmt), 64'd0);
        check("arst_ill", 64'(o_illegal), 64'd0);
        check("arst_tag", 64'(o_tag), 64'd0);
        check("arst_valid32", 64'(d2_valid), 64'd0);
`ifdef IMMGEN_ILLEGAL_CNT_EN
        check("arst_cnt", 64'(o_illegal_cnt), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        send_chk("post_rst", 32'h00200093, 5'd22, 64'd2, 32'd2, 3'd1);
        @(negedge clk);
        check("post_rst_drain", 64'(o_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised immediate generator for the decode stage; successor to the combinational sign extender.
- Accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake.
- Emits the XLEN-wide sign-extended immediate, a format code, an illegal flag and a pass-through tag, one cycle later.
- Includes a skid buffer so full throughput is kept under downstream backpressure.

Parameters:
- XLEN, 64, output immediate width; legal values 32 or 64.
- TAG_W, 5, width of the sideband tag (e.g. ROB/PC index) carried alongside.
- PRESHIFT, 1, 1 = architectural immediates (B/J bit0 = 0, U << 12); 0 = legacy unshifted immediates for the existing branch adder.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream instruction valid.
- o_ready  output  1  stage can accept input.
- i_instr  input  32  instruction word.
- i_tag  input  TAG_W  sideband tag.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_imm  output  XLEN  sign-extended immediate.
- o_fmt  output  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- o_illegal  output  1  opcode not recognised.
- o_tag  output  TAG_W  tag of the current result.

Behaviour:
- Decode is combinational on i_instr[6:0].
  - I: 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011 (imm 0, legal).
  - Anything else: fmt 7, o_illegal=1, imm 0.
- Immediates, sign bit always i_instr[31], extended to XLEN:
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
- PRESHIFT=0: B and J drop the trailing 0, and U = [31:12] sign-extended, with no shift.
- Datapath is two registers: main (drives outputs) and skid.
  - o_ready = !skid_valid.
  - Input transfer when i_valid && o_ready; output transfer when o_valid && i_ready.
- Input accepted while main is empty or draining: decoded result loads into main.
- Input accepted while main is held (o_valid && !i_ready): result loads into skid.
- Output transfer with skid full: skid moves to main, skid empties.
- Latency: exactly 1 cycle from input transfer to o_valid when unstalled. Throughput is 1 per cycle.
- Order is strictly preserved; no drop or duplication under any i_ready pattern.
- Outputs are stable while o_valid && !i_ready.
- Simultaneous input and output transfer with skid empty: main is replaced by the new result, and o_valid stays 1.
- i_instr/i_tag are ignored when i_valid=0; registers hold.
- Reset, asynchronous at any time including mid-stall:
  - main_valid = skid_valid = 0, so o_valid = 0 and o_ready = 1 immediately.
  - o_imm = 0, o_fmt = 0, o_illegal = 0, o_tag = 0.
  - In-flight data is discarded.
- XLEN=32: extension is a no-op beyond bit 31; otherwise identical.

Optional Feature:
- Macro: IMMGEN_ILLEGAL_CNT_EN.
- Defined: adds output o_illegal_cnt (16 bits).
  - Increments by 1 on every input transfer whose opcode is illegal.
  - Saturates at 0xFFFF.
  - Reset to 0 by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- XLEN=64, PRESHIFT=1, i_ready=1; i_instr=0xFFF00093 (addi -1), tag 3 -> next cycle o_valid=1, o_imm=0xFFFF_FFFF_FFFF_FFFF, o_fmt=1, o_tag=3.
- 0xFE20BC23 (sd x2,-8(x1)) -> o_imm=0xFFFF_FFFF_FFFF_FFF8, fmt 2.
- 0xFE000EE3 (beq -4) -> o_imm=...FFFC, fmt 3; with PRESHIFT=0 -> ...FFFE.
- 0x800000B7 (lui 0x80000) -> o_imm=0xFFFF_FFFF_8000_0000, fmt 4.
- 0x0080006F (jal +8) -> o_imm=8, fmt 5; with PRESHIFT=0 -> 4.
- 0x0000007F -> fmt 7, o_illegal=1, o_imm=0; with IMMGEN_ILLEGAL_CNT_EN, o_illegal_cnt increments by 1.
- Backpressure: stream tags 0..7 back-to-back, i_ready=0 for cycles 2-4 -> o_ready drops 1 cycle after the stall begins, all 8 results emerge in order, none lost or duplicated, outputs stable while stalled.
- Reset: assert reset mid-stall with both registers full -> o_valid=0 and o_ready=1 without waiting for a clock edge. After release, the first new input appears 1 cycle later.
